// File: rtl/pipelined_shifter.sv
// pipelined_shifter: registered log-depth barrel shifter/rotator with valid/ready flow control.
// Right shifts and rotates reuse the left network by reversing the operand on entry and the result on exit.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_b,
  input  logic [2:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam int LAT = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int BXW = LAT * LEVELS_PER_STAGE;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) rev[i] = x[WIDTH-1-i];
  endfunction

  function automatic logic is_right(input logic [2:0] m);
    return m == 3'b010 || m == 3'b011 || m == 3'b101;
  endfunction

  // One mux rank: shift left by 2^k, refilling the low bits with either the wrapped bits or the fill bit.
  function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] x, input int k, input logic rot, input logic f);
    logic [WIDTH-1:0] lo;
    lo = rot ? x >> (WIDTH - (1 << k)) : {WIDTH{f}} >> (WIDTH - (1 << k));
    return (x << (1 << k)) | lo;
  endfunction

  logic             v_q [LAT];
  logic [WIDTH-1:0] d_q [LAT];
  logic [SHW-1:0]   b_q [LAT];
  logic [2:0]       m_q [LAT];
  logic             f_q [LAT];
  logic             vi  [LAT];
  logic [WIDTH-1:0] di  [LAT];
  logic [SHW-1:0]   bi  [LAT];
  logic [2:0]       mi  [LAT];
  logic             fi  [LAT];
  logic [WIDTH-1:0] d_o [LAT];
  logic             z_q;
  logic             stall;
  logic             pass;

  assign stall     = v_q[LAT-1] && !out_ready;
  assign in_ready  = !stall;
  assign pass      = in_mode == 3'b000 || in_mode[2:1] == 2'b11;
  assign out_valid = v_q[LAT-1];
  assign out_data  = d_q[LAT-1];
  assign out_zero  = z_q;

  always_comb begin
    vi[0] = in_valid;
    di[0] = !in_valid ? '0 : is_right(in_mode) ? rev(in_a) : in_a;
    bi[0] = in_valid && !pass ? in_b : '0;
    mi[0] = in_valid ? in_mode : 3'b000;
    fi[0] = in_valid && in_mode == 3'b010 && in_a[WIDTH-1];
    for (int s = 1; s < LAT; s++) begin
      vi[s] = v_q[s-1];
      di[s] = d_q[s-1];
      bi[s] = b_q[s-1];
      mi[s] = m_q[s-1];
      fi[s] = f_q[s-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] x;
    logic [BXW-1:0]   bx;
    for (int s = 0; s < LAT; s++) begin
      x  = di[s];
      bx = BXW'(bi[s]);
      for (int j = 0; j < LEVELS_PER_STAGE; j++)
        if (bx[s*LEVELS_PER_STAGE+j]) x = lvl(x, s*LEVELS_PER_STAGE+j, mi[s][2], fi[s]);
      d_o[s] = s == LAT-1 && is_right(mi[s]) ? rev(x) : x;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < LAT; s++) begin
        v_q[s] <= 1'b0;
        d_q[s] <= '0;
        b_q[s] <= '0;
        m_q[s] <= 3'b000;
        f_q[s] <= 1'b0;
      end
      z_q <= 1'b0;
    end else if (!stall) begin
      for (int s = 0; s < LAT; s++) begin
        v_q[s] <= vi[s];
        d_q[s] <= d_o[s];
        b_q[s] <= bi[s];
        m_q[s] <= mi[s];
        f_q[s] <= fi[s];
      end
      z_q <= vi[LAT-1] && ~|d_o[LAT-1];
    end
  end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: random and directed checks of pipelined_shifter against a bitwise reference model.
module tb_pipelined_shifter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_a, out_data;
  logic [4:0] in_b;
  logic [2:0] in_mode;
  logic v8, r8, ov8, z8;
  logic [7:0] a8, d8;
  logic [2:0] b8, m8;
  logic v64, r64, ov64, z64;
  logic [63:0] a64, d64;
  logic [5:0] b64;
  logic [2:0] m64;

  pipelined_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero));
  pipelined_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(3)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_mode(m8), .out_valid(ov8), .out_ready(1'b1), .out_data(d8), .out_zero(z8));
  pipelined_shifter #(.WIDTH(64), .LEVELS_PER_STAGE(2)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(v64), .in_ready(r64), .in_a(a64), .in_b(b64),
    .in_mode(m64), .out_valid(ov64), .out_ready(1'b1), .out_data(d64), .out_zero(z64));

  typedef struct { logic [31:0] d; int t; } exp_t;
  exp_t q[$];
  exp_t ex;
  logic [63:0] e;
  int n_vec = 0, n_bad = 0, cyc = 0, n_out = 0;
  bit lat_chk = 1'b1, stall_prev = 1'b0;
  logic [31:0] data_prev;
  logic zero_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each result bit is looked up at its source position in the operand.
  function automatic logic [63:0] ref_model(input logic [63:0] a, input int b, input logic [2:0] m, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      case (m)
        3'd1: r[i] = i - b >= 0 ? a[i-b] : 1'b0;
        3'd2: r[i] = i + b < w ? a[i+b] : a[w-1];
        3'd3: r[i] = i + b < w ? a[i+b] : 1'b0;
        3'd4: r[i] = a[(i - b + w) % w];
        3'd5: r[i] = a[(i + b) % w];
        default: r[i] = a[i];
      endcase
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) stall_prev = 1'b0;
    else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (stall_prev) begin
        check("hold_data", out_data, data_prev);
        check("hold_zero", out_zero, zero_prev);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) check("stale", q.size(), 1);
        else begin
          ex = q.pop_front();
          check("data", out_data, ex.d);
          check("zero", out_zero, ex.d == 0);
          if (lat_chk) check("latency", cyc - ex.t, 5);
        end
      end
      if (in_valid && in_ready) begin
        e = ref_model({32'b0, in_a}, int'(in_b), in_mode, 32);
        q.push_back('{e[31:0], cyc});
      end
      stall_prev = out_valid && !out_ready;
      data_prev = out_data;
      zero_prev = out_zero;
    end
  end

  task automatic send(input logic [31:0] a, input int b, input logic [2:0] m);
    int n = 0;
    bit acc;
    in_valid = 1'b1; in_a = a; in_b = b[4:0]; in_mode = m;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_s(input logic [63:0] a, input int b, input logic [2:0] m, input int w);
    int n;
    logic [63:0] ev, got;
    logic ov, z, rdy;
    ev = ref_model(a, b, m, w);
    if (w == 8) begin v8 = 1'b1; a8 = a[7:0]; b8 = b[2:0]; m8 = m; end
    else begin v64 = 1'b1; a64 = a; b64 = b[5:0]; m64 = m; end
    @(negedge clk);
    rdy = w == 8 ? r8 : r64;
    check("s_ready", rdy, 1);
    n = 0;
    do begin
      @(posedge clk); #1 v8 = 1'b0; v64 = 1'b0;
      @(negedge clk); n++;
      ov = w == 8 ? ov8 : ov64;
    end while (!ov && n < 20);
    got = w == 8 ? {56'b0, d8} : d64;
    z = w == 8 ? z8 : z64;
    check("s_latency", n, w == 8 ? 1 : 3);
    check("s_data", got, ev);
    check("s_zero", z, ev == 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pats [6];
    int shs [4];
    int n0, n;
    pats = '{32'h80000000, 32'h00000080, 32'h00000001, 32'h7fffffff, 32'hffffff7f, 32'hfffffffe};
    shs = '{31, 7, 1, 0};
    in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; out_ready = 1;
    v8 = 0; a8 = 0; b8 = 0; m8 = 0; v64 = 0; a64 = 0; b64 = 0; m64 = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_zero", out_zero, 0);
    check("rst_data", out_data, 0);
    reset_n = 1'b1;
    #1 check("rst_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int m = 1; m <= 3; m++)
      for (int p = 0; p < 6; p++)
        for (int s = 0; s < 4; s++) send(pats[p], shs[s], 3'(m));
    repeat (8) @(posedge clk); #1;

    send(32'h80000001, 1, 3'b100);
    send(32'h80000001, 1, 3'b101);
    send(32'h12345678, 0, 3'b100);
    send(32'h12345678, 4, 3'b101);
    send(32'h00000001, 31, 3'b100);
    send(32'hdeadbeef, 5, 3'b110);
    send(32'hdeadbeef, 9, 3'b111);
    send(32'hdeadbeef, 3, 3'b000);
    send(32'h00000001, 1, 3'b011);
    send(32'h80000000, 31, 3'b010);
    repeat (8) @(posedge clk); #1;

    lat_chk = 1'b0;
    n0 = n_out;
    fork
      for (int i = 0; i < 8; i++) send($urandom, $urandom_range(0, 31), 3'($urandom_range(0, 5)));
      begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
        out_ready = 1'b0;
        repeat (3) @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk); #1;
    check("bp_count", n_out - n0, 8);
    check("bp_drain", q.size(), 0);

    lat_chk = 1'b1;
    out_ready = 1'b0;
    send(32'h0000ffff, 4, 3'b001);
    send(32'h0f0f0f0f, 8, 3'b100);
    send(32'h80000000, 3, 3'b010);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
    check("mid_pre_valid", out_valid, 1);
    #3 reset_n = 1'b0;
    #1 check("mid_valid", out_valid, 0);
    check("mid_ready", in_ready, 1);
    q.delete();
    out_ready = 1'b1;
    @(posedge clk); #4 reset_n = 1'b1;
    n0 = n_out;
    repeat (10) @(posedge clk); #1;
    check("mid_no_stale", n_out - n0, 0);
    send(32'h00000001, 31, 3'b001);
    repeat (8) @(posedge clk); #1;
    check("mid_drain", q.size(), 0);

    lat_chk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom;
      in_b = 5'($urandom);
      in_mode = 3'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("rand_drain", q.size(), 0);

    run_s(64'h81, 3, 3'b010, 8);
    run_s(64'h81, 3, 3'b101, 8);
    run_s(64'h5a, 7, 3'b100, 8);
    run_s(64'h1, 63, 3'b001, 64);
    run_s({$urandom, $urandom}, $urandom_range(0, 63), 3'($urandom_range(0, 7)), 64);
    run_s(64'h8000000000000000, 63, 3'b010, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
